// File: rtl/issue_scoreboard.sv
// Issue stage: integer register file, per-register busy scoreboard, RAW/WAW stall with
// same-cycle writeback bypass, and a registered backpressurable issue slot toward EXE.
module issue_scoreboard #(
  parameter int unsigned REG_WIDTH  = 5,
  parameter int unsigned CTRL_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_WIDTH-1:0]  id_rs1,
  input  logic [REG_WIDTH-1:0]  id_rs2,
  input  logic [REG_WIDTH-1:0]  id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_writes_rd,
  input  logic [31:0]           id_pc,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic                  wb_wr_en,
  input  logic                  wb_clr,
  input  logic [REG_WIDTH-1:0]  wb_rd,
  input  logic [31:0]           wb_wr_data,
  input  logic                  flush,
  output logic                  ix_valid,
  input  logic                  ix_ready,
  output logic [31:0]           ix_rs1_data,
  output logic [31:0]           ix_rs2_data,
  output logic [REG_WIDTH-1:0]  ix_rd,
  output logic                  ix_writes_rd,
  output logic [31:0]           ix_pc,
  output logic [CTRL_WIDTH-1:0] ix_ctrl,
  output logic [31:0]           busy_mask
);

  localparam int unsigned NumRegs = 2 ** REG_WIDTH;

  logic [31:0] rf [NumRegs];

  logic [31:0]           busy_q, busy_d;
  logic                  ix_valid_q, ix_valid_d;
  logic [31:0]           ix_rs1_data_q, ix_rs2_data_q;
  logic [REG_WIDTH-1:0]  ix_rd_q;
  logic                  ix_writes_rd_q;
  logic [31:0]           ix_pc_q;
  logic [CTRL_WIDTH-1:0] ix_ctrl_q;

  logic        wb_any;
  logic        hazard;
  logic        accept;
  logic [31:0] rs1_data, rs2_data;

  assign wb_any = wb_wr_en | wb_clr;

  // Register file write is deliberately outside the reset branch: it still happens under rst.
  always_ff @(posedge clk) begin
    if (wb_wr_en && wb_rd != '0) begin
      rf[wb_rd] <= wb_wr_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (id_rs1 != '0) begin
      rs1_data = (wb_wr_en && wb_rd == id_rs1) ? wb_wr_data : rf[id_rs1];
    end
    if (id_rs2 != '0) begin
      rs2_data = (wb_wr_en && wb_rd == id_rs2) ? wb_wr_data : rf[id_rs2];
    end
  end

  // A writeback retiring in this cycle releases its register for a same-cycle accept.
  always_comb begin
    hazard = 1'b0;
    if (id_uses_rs1 && busy_q[id_rs1] && !(wb_any && wb_rd == id_rs1)) hazard = 1'b1;
    if (id_uses_rs2 && busy_q[id_rs2] && !(wb_any && wb_rd == id_rs2)) hazard = 1'b1;
    if (id_writes_rd && busy_q[id_rd] && !(wb_any && wb_rd == id_rd)) hazard = 1'b1;
  end

  assign id_ready = !rst && !flush && !hazard && (!ix_valid_q || ix_ready);
  assign accept   = id_valid && id_ready;

  always_comb begin
    busy_d = busy_q;
    if (wb_any) busy_d[wb_rd] = 1'b0;
    if (accept && id_writes_rd && id_rd != '0) busy_d[id_rd] = 1'b1;
    // Dropping the held op means its writeback never comes, so release its destination here.
    if (flush && ix_valid_q && ix_writes_rd_q && ix_rd_q != '0) busy_d[ix_rd_q] = 1'b0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    ix_valid_d = ix_valid_q;
    if (accept) begin
      ix_valid_d = 1'b1;
    end else if (flush || ix_ready) begin
      ix_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q         <= '0;
      ix_valid_q     <= 1'b0;
      ix_rs1_data_q  <= '0;
      ix_rs2_data_q  <= '0;
      ix_rd_q        <= '0;
      ix_writes_rd_q <= 1'b0;
      ix_pc_q        <= '0;
      ix_ctrl_q      <= '0;
    end else begin
      busy_q     <= busy_d;
      ix_valid_q <= ix_valid_d;
      if (accept) begin
        ix_rs1_data_q  <= rs1_data;
        ix_rs2_data_q  <= rs2_data;
        ix_rd_q        <= id_rd;
        ix_writes_rd_q <= id_writes_rd;
        ix_pc_q        <= id_pc;
        ix_ctrl_q      <= id_ctrl;
      end
    end
  end

  assign ix_valid     = ix_valid_q;
  assign ix_rs1_data  = ix_rs1_data_q;
  assign ix_rs2_data  = ix_rs2_data_q;
  assign ix_rd        = ix_rd_q;
  assign ix_writes_rd = ix_writes_rd_q;
  assign ix_pc        = ix_pc_q;
  assign ix_ctrl      = ix_ctrl_q;
  assign busy_mask    = busy_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: stall/bypass, x0, backpressure, WAW, flush, reset.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_writes_rd;
  logic [31:0] id_pc;
  logic [63:0] id_ctrl;
  logic        wb_wr_en, wb_clr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wr_data;
  logic        flush;
  logic        ix_valid, ix_ready;
  logic [31:0] ix_rs1_data, ix_rs2_data;
  logic [4:0]  ix_rd;
  logic        ix_writes_rd;
  logic [31:0] ix_pc;
  logic [63:0] ix_ctrl;
  logic [31:0] busy_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.REG_WIDTH(5), .CTRL_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd),
    .id_pc(id_pc), .id_ctrl(id_ctrl),
    .wb_wr_en(wb_wr_en), .wb_clr(wb_clr), .wb_rd(wb_rd), .wb_wr_data(wb_wr_data),
    .flush(flush),
    .ix_valid(ix_valid), .ix_ready(ix_ready),
    .ix_rs1_data(ix_rs1_data), .ix_rs2_data(ix_rs2_data),
    .ix_rd(ix_rd), .ix_writes_rd(ix_writes_rd),
    .ix_pc(ix_pc), .ix_ctrl(ix_ctrl),
    .busy_mask(busy_mask)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic present(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic wr,
                         input logic [31:0] pc);
    id_valid = 1'b1;
    id_rs1 = rs1; id_uses_rs1 = u1;
    id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_writes_rd = wr;
    id_pc = pc; id_ctrl = {32'hC0DE0000, pc};
  endtask

  task automatic wb_none();
    wb_wr_en = 1'b0; wb_clr = 1'b0; wb_rd = '0; wb_wr_data = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ix_ready = 1'b1;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_writes_rd = 1'b0;
    id_pc = '0; id_ctrl = '0;
    wb_none();

    // Reset
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 32'h10);
    mid(); check("rst_id_ready", 64'(id_ready), 64'd0);
    cyc();
    check("rst_ix_valid", 64'(ix_valid), 64'd0);
    check("rst_busy", 64'(busy_mask), 64'd0);
    check("rst_ix_pc", 64'(ix_pc), 64'd0);
    check("rst_ix_ctrl", ix_ctrl, 64'd0);
    rst = 1'b0;

    // RAW stall then bypass
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h100);
    mid(); check("raw_first_ready", 64'(id_ready), 64'd1);
    cyc();
    check("raw_busy5", 64'(busy_mask), 64'h20);
    check("raw_ix_pc", 64'(ix_pc), 64'h100);
    present(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 32'h104);
    mid(); check("raw_stall0", 64'(id_ready), 64'd0);
    cyc();
    check("raw_slot_drained", 64'(ix_valid), 64'd0);
    mid(); check("raw_stall1", 64'(id_ready), 64'd0);
    cyc();
    wb_wr_en = 1'b1; wb_rd = 5'd5; wb_wr_data = 32'h00001234;
    mid(); check("raw_bypass_ready", 64'(id_ready), 64'd1);
    cyc();
    wb_none(); id_valid = 1'b0;
    check("raw_rs1_data", 64'(ix_rs1_data), 64'h1234);
    check("raw_ix_pc2", 64'(ix_pc), 64'h104);
    check("raw_busy", 64'(busy_mask), 64'h40);
    wb_clr = 1'b1; wb_rd = 5'd6;
    cyc();
    wb_none();
    check("clr_busy6", 64'(busy_mask), 64'd0);

    // x0: no busy, write discarded, no bypass
    present(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 32'h200);
    wb_wr_en = 1'b1; wb_rd = 5'd0; wb_wr_data = 32'hFFFFFFFF;
    cyc();
    wb_none(); id_valid = 1'b0;
    check("x0_busy", 64'(busy_mask), 64'd0);
    check("x0_rs1_data", 64'(ix_rs1_data), 64'd0);
    // Write a non-busy register, then read it and x5 from the file
    wb_wr_en = 1'b1; wb_rd = 5'd3; wb_wr_data = 32'hCAFE0003;
    cyc();
    wb_none();
    check("wb_nonbusy_busy", 64'(busy_mask), 64'd0);
    present(5'd5, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 32'h300);
    cyc();
    check("rf_rs1", 64'(ix_rs1_data), 64'h1234);
    check("rf_rs2", 64'(ix_rs2_data), 64'hCAFE0003);

    // Backpressure
    ix_ready = 1'b0;
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h400);
    mid(); check("bp_id_ready", 64'(id_ready), 64'd0);
    cyc();
    check("bp_ix_pc_hold", 64'(ix_pc), 64'h300);
    check("bp_ix_valid", 64'(ix_valid), 64'd1);
    check("bp_busy", 64'(busy_mask), 64'd0);
    ix_ready = 1'b1;
    mid(); check("bp_release_ready", 64'(id_ready), 64'd1);
    cyc();
    check("bp_new_pc", 64'(ix_pc), 64'h400);
    check("bp_busy7", 64'(busy_mask), 64'h80);

    // WAW with same-edge clear/set
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h500);
    mid(); check("waw_stall", 64'(id_ready), 64'd0);
    cyc();
    wb_wr_en = 1'b1; wb_rd = 5'd7; wb_wr_data = 32'h77;
    mid(); check("waw_ready", 64'(id_ready), 64'd1);
    cyc();
    wb_none(); id_valid = 1'b0;
    check("waw_busy7", 64'(busy_mask), 64'h80);
    check("waw_ix_pc", 64'(ix_pc), 64'h500);
    check("waw_ix_rd", 64'(ix_rd), 64'd7);

    // Flush drop
    wb_clr = 1'b1; wb_rd = 5'd7;
    cyc();
    wb_none();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h600);
    cyc();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 32'h604);
    cyc();
    check("fl_busy_pre", 64'(busy_mask), 64'h208);
    check("fl_ix_rd", 64'(ix_rd), 64'd9);
    flush = 1'b1;
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 32'h608);
    mid(); check("fl_id_ready", 64'(id_ready), 64'd0);
    cyc();
    flush = 1'b0; id_valid = 1'b0;
    check("fl_ix_valid", 64'(ix_valid), 64'd0);
    check("fl_busy", 64'(busy_mask), 64'h8);
    wb_clr = 1'b1; wb_rd = 5'd3;
    cyc();
    wb_none();
    check("fl_wbclr3", 64'(busy_mask), 64'd0);

    // Reset mid-stream; regfile write in the rst cycle persists
    ix_ready = 1'b0;
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 32'h700);
    cyc();
    check("mr_pre_valid", 64'(ix_valid), 64'd1);
    check("mr_pre_busy", 64'(busy_mask), 64'h800);
    rst = 1'b1; ix_ready = 1'b1;
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 32'h704);
    wb_wr_en = 1'b1; wb_rd = 5'd4; wb_wr_data = 32'h44;
    mid(); check("mr_id_ready", 64'(id_ready), 64'd0);
    cyc();
    rst = 1'b0; wb_none(); id_valid = 1'b0;
    check("mr_ix_valid", 64'(ix_valid), 64'd0);
    check("mr_busy", 64'(busy_mask), 64'd0);
    check("mr_ix_pc", 64'(ix_pc), 64'd0);
    present(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h800);
    cyc();
    id_valid = 1'b0;
    check("mr_rf_write", 64'(ix_rs1_data), 64'h44);
    check("mr_ix_pc_new", 64'(ix_pc), 64'h800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
